// File: rtl/pcileech_reset_sequencer_if.sv
// Reset sequencer bus: host sideband inputs and
// ordered reset / WAKE# / status outputs.
interface pcileech_reset_sequencer_if;
  logic       soft_rst_req;
  logic       pcie_present;
  logic       pcie_perst_n;
  logic       wake_req;
  logic       rst_com;
  logic       ft601_rst_n;
  logic       rst_fifo;
  logic       rst_pcie;
  logic       pcie_wake_n;
  logic [2:0] seq_state;
  logic       seq_done;
  logic       led_pwronblink;

  modport master (
    output soft_rst_req,
    output pcie_present,
    output pcie_perst_n,
    output wake_req,
    input  rst_com,
    input  ft601_rst_n,
    input  rst_fifo,
    input  rst_pcie,
    input  pcie_wake_n,
    input  seq_state,
    input  seq_done,
    input  led_pwronblink
  );

  modport slave (
    input  soft_rst_req,
    input  pcie_present,
    input  pcie_perst_n,
    input  wake_req,
    output rst_com,
    output ft601_rst_n,
    output rst_fifo,
    output rst_pcie,
    output pcie_wake_n,
    output seq_state,
    output seq_done,
    output led_pwronblink
  );
endinterface

// File: rtl/pcileech_reset_sequencer.sv
// Ordered COM -> FIFO -> PCIe reset release with
// PERST#/PRSNT tracking, WAKE# pulse and power-on blink.
module pcileech_reset_sequencer #(
  parameter int PARAM_POR_CYCLES   = 64,
  parameter int PARAM_STAGE_GAP    = 8,
  parameter int PARAM_PERST_FILTER = 16,
  parameter int PARAM_WAKE_CYCLES  = 1000,
  parameter int PARAM_BLINK_BIT    = 24
) (
  input logic clk,
  input logic rst,
  pcileech_reset_sequencer_if.slave bus
);

  localparam int STG_MAX =
    (PARAM_POR_CYCLES > PARAM_STAGE_GAP) ?
    PARAM_POR_CYCLES : PARAM_STAGE_GAP;
  localparam int STG_W  = $clog2(STG_MAX + 1);
  localparam int FLT_W  = $clog2(PARAM_PERST_FILTER + 1);
  localparam int WAKE_W = $clog2(PARAM_WAKE_CYCLES + 1);
  localparam int TICK_W = PARAM_BLINK_BIT + 4;

  typedef enum logic [2:0] {
    S_POR        = 3'd0,
    S_COM        = 3'd1,
    S_FIFO       = 3'd2,
    S_WAIT_PERST = 3'd3,
    S_RUN        = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [STG_W-1:0]    stg_q, stg_d;
  logic                prs_s1_q, prs_s2_q;
  logic                perst_s1_q, perst_s2_q;
  logic                perst_filt_q, perst_filt_d;
  logic [FLT_W-1:0]    flt_q, flt_d;
  logic                wake_act_q, wake_act_d;
  logic [WAKE_W-1:0]   wake_cnt_q, wake_cnt_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic                rst_com_q, rst_com_d;
  logic                rst_fifo_q, rst_fifo_d;
  logic                rst_pcie_q, rst_pcie_d;
  logic                wake_n_q, wake_n_d;
  logic                done_q, done_d;
  logic                led_q, led_d;
  logic                link_ok;
  logic                stg_end_por;
  logic                stg_end_gap;

  // Filter flips after PARAM_PERST_FILTER stable synced cycles
  always_comb begin
    flt_d        = '0;
    perst_filt_d = perst_filt_q;
    if (perst_s2_q != perst_filt_q) begin
      if (flt_q == FLT_W'(PARAM_PERST_FILTER - 1)) begin
        perst_filt_d = perst_s2_q;
      end else begin
        flt_d = flt_q + FLT_W'(1);
      end
    end
  end

  assign link_ok     = perst_filt_d & prs_s2_q;
  assign stg_end_por = stg_q == STG_W'(PARAM_POR_CYCLES - 1);
  assign stg_end_gap = stg_q == STG_W'(PARAM_STAGE_GAP - 1);

  always_comb begin
    state_d = state_q;
    stg_d   = stg_q;
    case (state_q)
      S_POR: begin
        stg_d = stg_q + STG_W'(1);
        if (stg_end_por) state_d = S_COM;
      end
      S_COM: begin
        stg_d = stg_q + STG_W'(1);
        if (stg_end_gap) state_d = S_FIFO;
      end
      S_FIFO: begin
        stg_d = stg_q + STG_W'(1);
        if (stg_end_gap)
          state_d = link_ok ? S_RUN : S_WAIT_PERST;
      end
      S_WAIT_PERST: begin
        if (link_ok) state_d = S_RUN;
      end
      S_RUN: begin
        if (!link_ok) state_d = S_WAIT_PERST;
      end
      default: state_d = S_POR;
    endcase
    if (bus.soft_rst_req) state_d = S_POR;
    if (bus.soft_rst_req || state_d != state_q)
      stg_d = '0;
  end

  always_comb begin
    wake_act_d = wake_act_q;
    wake_cnt_d = wake_cnt_q;
    if (wake_act_q) begin
      if (wake_cnt_q == WAKE_W'(PARAM_WAKE_CYCLES - 1))
        wake_act_d = 1'b0;
      else
        wake_cnt_d = wake_cnt_q + WAKE_W'(1);
    end else if (bus.wake_req && prs_s2_q &&
                 (state_q == S_WAIT_PERST ||
                  state_q == S_RUN)) begin
      wake_act_d = 1'b1;
      wake_cnt_d = '0;
    end
    if (state_d == S_POR || !prs_s2_q)
      wake_act_d = 1'b0;
  end

  always_comb begin
    tick_d = tick_q;
    if (!tick_q[TICK_W-1]) tick_d = tick_q + TICK_W'(1);
    led_d      = tick_d[PARAM_BLINK_BIT] &
                 ~tick_d[TICK_W-1];
    rst_com_d  = state_d == S_POR;
    rst_fifo_d = state_d == S_POR || state_d == S_COM;
    rst_pcie_d = state_d != S_RUN;
    done_d     = state_d == S_RUN;
    wake_n_d   = ~wake_act_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_POR;
      stg_q        <= '0;
      prs_s1_q     <= 1'b0;
      prs_s2_q     <= 1'b0;
      perst_s1_q   <= 1'b0;
      perst_s2_q   <= 1'b0;
      perst_filt_q <= 1'b0;
      flt_q        <= '0;
      wake_act_q   <= 1'b0;
      wake_cnt_q   <= '0;
      tick_q       <= '0;
      rst_com_q    <= 1'b1;
      rst_fifo_q   <= 1'b1;
      rst_pcie_q   <= 1'b1;
      wake_n_q     <= 1'b1;
      done_q       <= 1'b0;
      led_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      stg_q        <= stg_d;
      prs_s1_q     <= bus.pcie_present;
      prs_s2_q     <= prs_s1_q;
      perst_s1_q   <= bus.pcie_perst_n;
      perst_s2_q   <= perst_s1_q;
      perst_filt_q <= perst_filt_d;
      flt_q        <= flt_d;
      wake_act_q   <= wake_act_d;
      wake_cnt_q   <= wake_cnt_d;
      tick_q       <= tick_d;
      rst_com_q    <= rst_com_d;
      rst_fifo_q   <= rst_fifo_d;
      rst_pcie_q   <= rst_pcie_d;
      wake_n_q     <= wake_n_d;
      done_q       <= done_d;
      led_q        <= led_d;
    end
  end

  assign bus.rst_com        = rst_com_q;
  assign bus.ft601_rst_n    = ~rst_com_q;
  assign bus.rst_fifo       = rst_fifo_q;
  assign bus.rst_pcie       = rst_pcie_q;
  assign bus.pcie_wake_n    = wake_n_q;
  assign bus.seq_state      = state_q;
  assign bus.seq_done       = done_q;
  assign bus.led_pwronblink = led_q;

endmodule
